// File: rtl/rx_phase_sync_pkg.sv
// Shared definitions for the receive phase synchroniser: FSM encoding,
// derived widths and the phase-switch hysteresis shift.
package rx_phase_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_DECIDE = 2'd2,
        ST_TRACK  = 2'd3
    } state_e;

    // Challenger must beat the incumbent by more than acc >> HYST_SH (12.5%).
    localparam int HYST_SH = 3;

    function automatic int calc_nb_ph(input int os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction

    function automatic int calc_nb_acc(input int nb, input int log2_win);
        return nb + log2_win;
    endfunction

endpackage

// File: rtl/rx_phase_sync_acc.sv
// Per-phase energy accumulators (sum of |sample| per oversampling phase)
// with an argmax that resolves ties toward the lowest phase index.
module phase_energy_acc
    import rx_phase_sync_pkg::*;
#(
    parameter int NB     = 8,
    parameter int OS     = 4,
    parameter int NB_ACC = 18,
    parameter int NB_PH  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 restart_i,
    input  logic                 acc_en_i,
    input  logic [NB_PH-1:0]     phase_i,
    input  logic [NB_PH-1:0]     sel_i,
    input  logic signed [NB-1:0] sample_i,
    output logic [NB_PH-1:0]     best_o,
    output logic [NB_ACC-1:0]    acc_best_o,
    output logic [NB_ACC-1:0]    acc_sel_o
);

    // -2^(NB-1) wraps to +2^(NB-1), which still fits the unsigned NB-bit result.
    function automatic logic [NB-1:0] abs_mag(input logic signed [NB-1:0] x);
        logic [NB-1:0] ux;
        ux = x;
        return ux[NB-1] ? (~ux + 1'b1) : ux;
    endfunction

    logic [NB-1:0]     mag;
    logic [NB_ACC-1:0] acc_q [OS];
    logic [NB_ACC-1:0] acc_d [OS];

    assign mag = abs_mag(sample_i);

    always_comb begin
        for (int p = 0; p < OS; p++) begin
            acc_d[p] = acc_q[p];
            if (clear_i) begin
                acc_d[p] = '0;
            end else if (restart_i) begin
                acc_d[p] = (p == 0) ? NB_ACC'(mag) : '0;
            end else if (acc_en_i && (phase_i == NB_PH'(p))) begin
                acc_d[p] = acc_q[p] + NB_ACC'(mag);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < OS; p++) acc_q[p] <= '0;
        end else begin
            for (int p = 0; p < OS; p++) acc_q[p] <= acc_d[p];
        end
    end

    always_comb begin
        best_o     = '0;
        acc_best_o = acc_q[0];
        for (int p = 1; p < OS; p++) begin
            if (acc_q[p] > acc_best_o) begin
                acc_best_o = acc_q[p];
                best_o     = NB_PH'(p);
            end
        end
    end

    assign acc_sel_o = acc_q[sel_i];

endmodule

// File: rtl/rx_phase_sync.sv
// Receive timing recovery: picks the oversampling phase with the highest
// mean |sample| per window and slices one bit per symbol at that phase.
module rx_phase_sync
    import rx_phase_sync_pkg::*;
#(
    parameter int  NB       = 8,
    parameter int  OS       = 4,
    parameter int  LOG2_WIN = 10,
    localparam int NB_PH    = calc_nb_ph(OS),
    localparam int NB_ACC   = calc_nb_acc(NB, LOG2_WIN)
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic signed [NB-1:0] i_sample,
    input  logic                 i_force_en,
    input  logic [NB_PH-1:0]     i_force_offset,
    output logic [NB_PH-1:0]     o_offset,
    output logic                 o_locked,
    output logic                 o_rx_bit,
    output logic                 o_rx_valid
);

    state_e              state_q, state_d;
    logic [NB_PH-1:0]    ph_cnt_q, ph_cnt_d, phase;
    logic [LOG2_WIN-1:0] sym_q, sym_d;
    logic [NB_PH-1:0]    sel_q, sel_d, offset_q;
    logic                locked_q, locked_d;
    logic                rx_bit_q, rx_valid_q;
    logic                acc_clear, acc_restart, acc_en;
    logic                win_end, beats_sel, emit;
    logic [NB_PH-1:0]    best;
    logic [NB_ACC-1:0]   acc_best, acc_sel;
    logic [NB_ACC:0]     hyst_thr;

    assign phase    = i_valid ? '0 : ph_cnt_q;
    assign ph_cnt_d = i_valid ? NB_PH'(1)
                    : ((ph_cnt_q == NB_PH'(OS - 1)) ? '0 : ph_cnt_q + 1'b1);

    assign win_end   = (sym_q == '1) && (phase == NB_PH'(OS - 1));
    assign hyst_thr  = {1'b0, acc_sel} + ({1'b0, acc_sel} >> HYST_SH);
    assign beats_sel = {1'b0, acc_best} > hyst_thr;

    phase_energy_acc #(
        .NB     (NB),
        .OS     (OS),
        .NB_ACC (NB_ACC),
        .NB_PH  (NB_PH)
    ) u_acc (
        .clk_i      (clock),
        .rst_i      (i_reset),
        .clear_i    (acc_clear),
        .restart_i  (acc_restart),
        .acc_en_i   (acc_en),
        .phase_i    (phase),
        .sel_i      (sel_q),
        .sample_i   (i_sample),
        .best_o     (best),
        .acc_best_o (acc_best),
        .acc_sel_o  (acc_sel)
    );

    // locked_q is low in DECIDE only when the window that just closed was ACQ.
    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        sel_d       = sel_q;
        locked_d    = locked_q;
        acc_clear   = 1'b0;
        acc_restart = 1'b0;
        acc_en      = 1'b0;
        if (!i_enable) begin
            state_d   = ST_IDLE;
            acc_clear = 1'b1;
            sym_d     = '0;
            locked_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sym_d    = '0;
                    locked_d = 1'b0;
                    if (i_valid) begin
                        state_d = ST_ACQ;
                        acc_en  = 1'b1;
                    end else begin
                        acc_clear = 1'b1;
                    end
                end
                ST_ACQ, ST_TRACK: begin
                    acc_en = 1'b1;
                    if (i_valid) sym_d = sym_q + 1'b1;
                    if (win_end) state_d = ST_DECIDE;
                end
                ST_DECIDE: begin
                    acc_restart = 1'b1;
                    sym_d       = '0;
                    state_d     = ST_TRACK;
                    if (!locked_q) begin
                        sel_d    = best;
                        locked_d = 1'b1;
                    end else if (beats_sel) begin
                        sel_d = best;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign emit = (phase == offset_q) && i_enable && (locked_q || i_force_en);

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            ph_cnt_q   <= '0;
            sym_q      <= '0;
            sel_q      <= '0;
            locked_q   <= 1'b0;
            offset_q   <= '0;
            rx_bit_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            sym_q      <= sym_d;
            sel_q      <= sel_d;
            locked_q   <= locked_d;
            offset_q   <= i_force_en ? i_force_offset : sel_q;
            rx_valid_q <= emit;
            if (emit) rx_bit_q <= i_sample[NB-1];
        end
    end

    assign o_offset   = offset_q;
    assign o_locked   = locked_q;
    assign o_rx_bit   = rx_bit_q;
    assign o_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_rx_phase_sync.sv
// Directed bench for rx_phase_sync with OS=4, NB=8 and a 16-symbol window.
module tb_rx_phase_sync;

    localparam int NB       = 8;
    localparam int OS       = 4;
    localparam int LOG2_WIN = 4;

    logic                 clock = 1'b0;
    logic                 i_reset;
    logic                 i_enable;
    logic                 i_valid;
    logic signed [NB-1:0] i_sample;
    logic                 i_force_en;
    logic [1:0]           i_force_offset;
    logic [1:0]           o_offset;
    logic                 o_locked;
    logic                 o_rx_bit;
    logic                 o_rx_valid;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] rv, rb, rvacc;

    rx_phase_sync #(
        .NB       (NB),
        .OS       (OS),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .i_sample       (i_sample),
        .i_force_en     (i_force_en),
        .i_force_offset (i_force_offset),
        .o_offset       (o_offset),
        .o_locked       (o_locked),
        .o_rx_bit       (o_rx_bit),
        .o_rx_valid     (o_rx_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int s, input logic v);
        i_sample = 8'(s);
        i_valid  = v;
        @(posedge clock);
        #1;
    endtask

    // One symbol: phase 0..3 samples; rv/rb capture the output seen after each sample.
    task automatic sym(input int a, input int b, input int c, input int d);
        int s [4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int k = 0; k < 4; k++) begin
            cyc(s[k], (k == 0));
            rv[k] = o_rx_valid;
            rb[k] = o_rx_bit;
        end
        i_valid = 1'b0;
        rvacc   = rvacc | rv;
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_sample = '0;
        i_force_en = 1'b0; i_force_offset = 2'd0;
        rv = '0; rb = '0; rvacc = '0;

        // Reset state, then a forced stream interrupted by an asynchronous reset
        repeat (3) @(posedge clock);
        #1;
        chk("rst_offset", o_offset, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_rx_valid", o_rx_valid, 0);
        chk("rst_rx_bit", o_rx_bit, 0);
        i_reset = 1'b0;
        i_enable = 1'b1; i_force_en = 1'b1; i_force_offset = 2'd1;
        sym(0, -20, 0, 0);
        sym(0, -20, 0, 0);
        chk("prerst_rv", rv, 4'b0010);
        chk("prerst_bit", rb[1], 1);
        chk("prerst_offset", o_offset, 1);
        #2 i_reset = 1'b1;
        #1;
        chk("midrst_offset", o_offset, 0);
        chk("midrst_locked", o_locked, 0);
        chk("midrst_rx_valid", o_rx_valid, 0);
        chk("midrst_rx_bit", o_rx_bit, 0);
        @(posedge clock);
        #1;
        i_reset = 1'b0; i_force_en = 1'b0; i_force_offset = 2'd0;

        // Acquisition: phase 2 dominant (1600 vs 160)
        i_enable = 1'b1;
        rvacc = '0;
        for (int n = 0; n < 16; n++) sym(10, -10, (n % 2 == 0) ? 100 : -100, 10);
        chk("acq_no_valid", rvacc, 0);
        chk("acq_not_locked", o_locked, 0);
        cyc(10, 1'b1);
        chk("lock_locked", o_locked, 1);
        chk("lock_offset_lag", o_offset, 0);
        cyc(-10, 1'b0);
        chk("lock_offset", o_offset, 2);
        cyc(100, 1'b0);
        chk("first_valid", o_rx_valid, 1);
        chk("first_bit", o_rx_bit, 0);
        cyc(10, 1'b0);
        chk("valid_pulse", o_rx_valid, 0);
        sym(10, -10, -100, 10);
        chk("track_rv", rv, 4'b0100);
        chk("track_bit", rb[2], 1);

        // Tie across all phases selects phase 0
        i_enable = 1'b0;
        sym(0, 0, 0, 0);
        chk("dis_locked", o_locked, 0);
        chk("dis_offset_held", o_offset, 2);
        i_enable = 1'b1;
        for (int n = 0; n < 16; n++) sym(50, -50, 50, -50);
        sym(50, -50, 50, -50);
        chk("tie_offset", o_offset, 0);
        chk("tie_locked", o_locked, 1);
        sym(50, -50, 50, -50);
        chk("tie_rv", rv, 4'b0001);
        chk("tie_bit", rb[0], 0);

        // -128 at phase 3 outweighs 127 elsewhere (2048 vs 2032)
        i_enable = 1'b0;
        sym(0, 0, 0, 0);
        i_enable = 1'b1;
        for (int n = 0; n < 16; n++) sym(127, 127, 127, -128);
        sym(127, 127, 127, -128);
        chk("neg128_offset", o_offset, 3);
        chk("neg128_rv", rv, 4'b1000);
        chk("neg128_bit", rb[3], 1);

        // Hysteresis: phase 1 at 1750 and 1800 keeps phase 2 (1600); 1900 switches
        i_enable = 1'b0;
        sym(0, 0, 0, 0);
        i_enable = 1'b1;
        for (int n = 0; n <= 64; n++) begin
            int w, i, p1;
            w = n / 16;
            i = n % 16;
            case (w)
                1:       p1 = (i < 15) ? 110 : 100;
                2:       p1 = (i < 15) ? 113 : 105;
                3:       p1 = (i < 15) ? 120 : 100;
                default: p1 = 10;
            endcase
            sym(10, p1, 100, -10);
            if (i == 0 && w >= 1) chk($sformatf("hyst_w%0d", w), o_offset, (w == 4) ? 1 : 2);
        end

        // Forced offset from IDLE: output without lock
        i_enable = 1'b0;
        sym(0, 0, 0, 0);
        chk("prefrc_offset", o_offset, 1);
        i_force_en = 1'b1; i_force_offset = 2'd3; i_enable = 1'b1;
        cyc(5, 1'b1);
        chk("frc_offset", o_offset, 3);
        cyc(5, 1'b0);
        cyc(5, 1'b0);
        cyc(-77, 1'b0);
        chk("frc_valid", o_rx_valid, 1);
        chk("frc_bit", o_rx_bit, 1);
        chk("frc_not_locked", o_locked, 0);
        sym(5, 5, 5, 77);
        chk("frc_rv", rv, 4'b1000);
        chk("frc_bit2", rb[3], 0);

        // Enable dropped at symbol 9 of ACQ: partial window must be discarded
        i_force_en = 1'b0; i_force_offset = 2'd0; i_enable = 1'b0;
        sym(0, 0, 0, 0);
        chk("unfrc_offset", o_offset, 1);
        rvacc = '0;
        i_enable = 1'b1;
        repeat (9) sym(0, 0, 0, 120);
        i_enable = 1'b0;
        repeat (2) sym(0, 0, 0, 120);
        i_enable = 1'b1;
        repeat (16) sym(60, 0, 0, 5);
        chk("reacq_no_valid", rvacc, 0);
        chk("reacq_not_locked", o_locked, 0);
        chk("reacq_offset_held", o_offset, 1);
        sym(60, 0, 0, 5);
        chk("reacq_locked", o_locked, 1);
        chk("reacq_offset", o_offset, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_phase_sync.md
Name: rx_phase_sync

Overview:
- Receive-side timing recovery stage. It sits directly downstream of the RC filter output and feeds the BER checker.
- It replaces the manual switch-selected sampling offset. Over fixed windows it measures the mean absolute sample amplitude at each of the OS oversampling phases and locks onto the phase with the highest energy.
- It then emits one decided bit per symbol: the sign of the sample at that phase.
- A force mode lets the switches still override the offset.

Parameters:
- NB, 8, sample width (signed, two's complement).
- OS, 4, oversampling factor; NB_PH = clog2(OS) = 2.
- LOG2_WIN, 10, window length = 2^LOG2_WIN symbols.
- NB_ACC, NB+LOG2_WIN, accumulator width; overflow impossible by construction.

Ports:
- clock, in, 1, system clock.
- i_reset, in, 1, reset: asynchronous, active-high.
- i_enable, in, 1, RX enable; low forces IDLE.
- i_valid, in, 1, symbol strobe from control; one pulse every OS clocks; marks phase 0.
- i_sample, in, NB, signed filter output; one new sample every clock.
- i_force_en, in, 1, use i_force_offset instead of the auto-selected phase.
- i_force_offset, in, NB_PH, forced sampling phase.
- o_offset, out, NB_PH, effective sampling phase (registered).
- o_locked, out, 1, auto-selection has completed at least one window since entering ACQ.
- o_rx_bit, out, 1, decided bit (1 = negative sample).
- o_rx_valid, out, 1, one-clock pulse per symbol when o_rx_bit is new.

Behaviour:
- Reset: all outputs are 0. State is IDLE. Phase counter, symbol counter and all accumulators are 0.
- Phase counter:
  - The current phase is 0 in any cycle with i_valid high; otherwise it is the count register.
  - The register loads 1 on i_valid; otherwise it increments modulo OS.
  - It runs whenever out of reset, regardless of i_enable.
- Magnitude: mag = |i_sample| as an NB-bit unsigned value. -2^(NB-1) maps to 2^(NB-1) (e.g. -128 -> 128) with no saturation.
- FSM states: IDLE, ACQ, DECIDE, TRACK.
- IDLE:
  - Accumulators are held at 0 and o_locked = 0.
  - Moves to ACQ on a cycle with i_enable && i_valid; that phase-0 sample is accumulated.
- ACQ and TRACK:
  - Each cycle, acc[phase] += mag.
  - The symbol counter increments on i_valid.
  - When the symbol counter equals 2^LOG2_WIN-1 and phase == OS-1, that sample is accumulated and the next state is DECIDE.
- DECIDE (exactly one cycle, always coincides with i_valid):
  - best = argmax(acc); on a tie the lowest index wins.
  - If coming from ACQ: sel <= best and o_locked <= 1.
  - If coming from TRACK: sel <= best only if acc[best] > acc[sel] + (acc[sel] >> 3), i.e. more than 12.5% hysteresis; otherwise sel is kept.
  - The same cycle restarts the window: acc[0] <= mag, other accumulators <= 0, symbol counter <= 0.
  - Next state is TRACK.
- o_offset <= i_force_en ? i_force_offset : sel, updated every clock (registered, 1-cycle lag).
- Bit output:
  - In the cycle after phase == o_offset, o_rx_bit <= i_sample[NB-1] (sign of that sample) and o_rx_valid = 1 for one clock.
  - Emitted only when i_enable && (o_locked || i_force_en); otherwise o_rx_valid = 0 and o_rx_bit holds its last value.
- i_enable low in any state:
  - Next state is IDLE; accumulators and symbol counter are cleared; o_locked <= 0.
  - sel and o_offset are held.
  - Re-enabling requires a full ACQ window before auto output resumes.
- A change of i_force_en or i_force_offset mid-window does not disturb accumulation. It takes effect on o_offset the next clock.
- Out-of-range i_valid spacing is not supported; the phase counter simply realigns on each i_valid.

Decomposition:
- Shared package rx_phase_sync_pkg:
  - state encoding localparams ST_IDLE / ST_ACQ / ST_DECIDE / ST_TRACK;
  - NB_PH and NB_ACC derivation functions;
  - hysteresis shift constant HYST_SH = 3.
- Sub-module phase_energy_acc: holds the OS accumulators (|x| generation, per-phase add, clear/restart-load) and the argmax tree with lowest-index tie rule.
- The top of the block keeps the FSM, the counters, the offset register and the bit decision.

Test Plan (OS=4, NB=8, LOG2_WIN=4 i.e. 16-symbol window, i_valid every 4 clocks):
1. Reset asserted mid-stream, then released -> all outputs 0, state IDLE, no o_rx_valid until a lock is achieved.
2. i_enable=1; phase 2 samples alternate ±100, other phases ±10 -> DECIDE 64 clocks after the first accumulated i_valid; o_locked=1; o_offset=2 one clock later. o_rx_valid then pulses every 4 clocks, with o_rx_bit equal to the sign of each phase-2 sample, 1 clock after it.
3. All phases at magnitude 50; plus one window containing -128 at phase 3 while the others are 127 -> tie selects offset 0; the -128 window selects offset 3 (acc 2048 vs 2032).
4. Locked at 2 with acc[2]=1600; next window acc[1]=1750 (<1800) -> offset stays 2; following window acc[1]=1900 -> offset becomes 1 after that DECIDE.
5. i_force_en=1, i_force_offset=3, i_enable=1 from IDLE -> o_offset=3 next clock; o_rx_valid every symbol immediately (no lock needed), o_rx_bit = sign of the phase-3 sample.
6. i_enable dropped at symbol 9 of the ACQ window, raised again 8 clocks later -> o_locked=0 and no o_rx_valid; a fresh 16-symbol window is required before lock, with o_offset held throughout.
